// File: rtl/fft_col_collect.sv
// Collects NPHASE butterfly result beats into one column frame, then hands it to
// the output bank; a second completed frame can wait in the capture bank.
module fft_col_collect #(
  parameter int WORD_W = 64,
  parameter int NMAC   = 4,
  parameter int NPHASE = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NMAC*2*WORD_W-1:0]             in_data,
  input  logic [1:0]                           in_phase,
  input  logic                                 flush,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NMAC*2*NPHASE*WORD_W-1:0]      out_frame,
  output logic [7:0]                           frame_cnt,
  output logic                                 phase_err
);

  localparam int          FRAME   = NMAC * 2 * NPHASE;
  localparam logic [1:0]  PH_LAST = 2'(NPHASE - 1);

  logic [1:0]        p_q;
  logic              pend_p0;
  logic              vld_p1;
  logic [7:0]        cnt_q;
  logic              err_q;
  logic [WORD_W-1:0] cap_p0  [FRAME];
  logic [WORD_W-1:0] cap_nxt [FRAME];
  logic [WORD_W-1:0] out_p1  [FRAME];

  logic accept;
  logic drain;
  logic last_beat;
  logic complete;
  logic load_new;
  logic load_pend;

  assign in_ready  = !pend_p0;
  assign accept    = in_valid && in_ready && !flush;
  assign drain     = vld_p1 && out_ready;
  assign last_beat = (p_q == PH_LAST);
  assign complete  = accept && last_beat;
  // A finished frame goes straight out when the output bank is free this edge.
  assign load_new  = complete && (!vld_p1 || drain);
  assign load_pend = pend_p0 && drain && !flush;

  // Stage p0: capture bank. Word k holds lane k/NPHASE at phase k%NPHASE,
  // i.e. MAC m lane j phase p lands at m*2*NPHASE + j*NPHASE + p.
  always_comb begin
    for (int k = 0; k < FRAME; k++) begin
      cap_nxt[k] = cap_p0[k];
      if (accept && (int'(p_q) == (k % NPHASE))) begin
        cap_nxt[k] = in_data[WORD_W*(k / NPHASE) +: WORD_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < FRAME; k++) begin
        cap_p0[k] <= '0;
      end
    end else begin
      for (int k = 0; k < FRAME; k++) begin
        cap_p0[k] <= cap_nxt[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q     <= '0;
      pend_p0 <= 1'b0;
      err_q   <= 1'b0;
    end else if (flush) begin
      p_q     <= '0;
      pend_p0 <= 1'b0;
    end else if (accept) begin
      p_q <= last_beat ? 2'd0 : p_q + 2'd1;
      if (in_phase != p_q) begin
        err_q <= 1'b1;
      end
      if (complete && !load_new) begin
        pend_p0 <= 1'b1;
      end
    end else if (load_pend) begin
      pend_p0 <= 1'b0;
    end
  end

  // Stage p1: output bank, held stable until the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < FRAME; k++) begin
        out_p1[k] <= '0;
      end
    end else if (load_new) begin
      for (int k = 0; k < FRAME; k++) begin
        out_p1[k] <= cap_nxt[k];
      end
    end else if (load_pend) begin
      for (int k = 0; k < FRAME; k++) begin
        out_p1[k] <= cap_p0[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (load_new || load_pend) begin
        vld_p1 <= 1'b1;
      end else if (drain) begin
        vld_p1 <= 1'b0;
      end
      if (drain) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < FRAME; g++) begin : g_pack
    assign out_frame[WORD_W*g +: WORD_W] = out_p1[g];
  end

  assign out_valid = vld_p1;
  assign frame_cnt = cnt_q;
  assign phase_err = err_q;

endmodule

// File: tb/tb_fft_col_collect.sv
// Bench for fft_col_collect: hand-written vector table, reset/wrap sequences and
// randomized traffic against a queue-based frame model.
module tb_fft_col_collect;

  localparam int W  = 64;
  localparam int NM = 4;
  localparam int NP = 4;
  localparam int FR = NM * 2 * NP;

  typedef logic [FR*W-1:0]   frame_t;
  typedef logic [NM*2*W-1:0] beat_t;

  typedef struct {
    bit v;
    int ph;
    bit fl;
    bit ord;
    int tag;
    int chk;
    bit e_rdy;
    bit e_ov;
    int e_cnt;
    bit e_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic [1:0] in_phase = 2'd0;
  beat_t      in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic       phase_err;
  logic [7:0] frame_cnt;
  frame_t     out_frame;

  int nvec = 0;
  int nerr = 0;

  frame_t q[$];
  frame_t last_out;
  frame_t mcap;
  int     mp;
  int     mcnt;
  bit     merr;

  vec_t tbl[$];

  fft_col_collect #(.WORD_W(W), .NMAC(NM), .NPHASE(NP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_phase(in_phase), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_frame(out_frame),
    .frame_cnt(frame_cnt), .phase_err(phase_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] tword(int tag, int m, int j, int ph);
    return {16'(tag), 16'(m), 16'(j), 16'(ph)};
  endfunction

  function automatic beat_t tbeat(int tag, int ph);
    beat_t b;
    for (int m = 0; m < NM; m++)
      for (int j = 0; j < 2; j++)
        b[W*(2*m+j) +: W] = tword(tag, m, j, ph);
    return b;
  endfunction

  function automatic vec_t mkv(bit v, int ph, bit fl, bit ord, int tag, int chk,
                               bit e_rdy, bit e_ov, int e_cnt, bit e_err);
    vec_t r;
    r.v = v; r.ph = ph; r.fl = fl; r.ord = ord; r.tag = tag; r.chk = chk;
    r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_cnt = e_cnt; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_frame(string nm, frame_t act, frame_t exp);
    int bad;
    bad = -1;
    nvec++;
    for (int k = FR - 1; k >= 0; k--)
      if (act[W*k +: W] !== exp[W*k +: W]) bad = k;
    if (bad >= 0) begin
      nerr++;
      $display("FAIL %s: word %0d got %h want %h", nm, bad, act[W*bad +: W], exp[W*bad +: W]);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_out = '0;
    mcap = '0;
    mp = 0;
    mcnt = 0;
    merr = 1'b0;
  endtask

  // Frames in flight: q[0] is what the consumer sees, q[1] is a waiting frame.
  task automatic model_step();
    int n0;
    bit pend;
    bit acc;
    bit drn;
    n0   = q.size();
    pend = (n0 == 2);
    acc  = in_valid && !pend && !flush;
    drn  = (n0 > 0) && out_ready;
    if (flush && pend) void'(q.pop_back());
    if (drn) begin
      last_out = q.pop_front();
      mcnt++;
    end
    if (acc) begin
      for (int m = 0; m < NM; m++)
        for (int j = 0; j < 2; j++)
          mcap[W*(m*2*NP + j*NP + mp) +: W] = in_data[W*(2*m+j) +: W];
      if (int'(in_phase) != mp) merr = 1'b1;
      if (mp == NP - 1) begin
        q.push_back(mcap);
        mp = 0;
      end else begin
        mp++;
      end
    end
    if (flush) mp = 0;
  endtask

  task automatic check_model(string nm);
    chk({nm, " in_ready"}, 64'(in_ready), (q.size() < 2) ? 64'd1 : 64'd0);
    chk({nm, " out_valid"}, 64'(out_valid), (q.size() > 0) ? 64'd1 : 64'd0);
    chk({nm, " frame_cnt"}, 64'(frame_cnt), 64'(mcnt % 256));
    chk({nm, " phase_err"}, 64'(phase_err), 64'(merr));
    chk_frame({nm, " out_frame"}, out_frame, (q.size() > 0) ? q[0] : last_out);
  endtask

  task automatic tick(string nm);
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model(nm);
  endtask

  // Called at a negedge; reset is raised between edges and checked before any clock.
  task automatic do_reset(string nm);
    in_valid = 1'b0;
    flush = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
    chk({nm, " out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, " frame_cnt"}, 64'(frame_cnt), 64'd0);
    chk({nm, " phase_err"}, 64'(phase_err), 64'd0);
    chk_frame({nm, " out_frame"}, out_frame, '0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic beat(bit v, int ph, int tag, bit ord, string nm);
    in_valid = v;
    in_phase = 2'(ph);
    in_data = tbeat(tag, ph);
    out_ready = ord;
    flush = 1'b0;
    tick(nm);
  endtask

  initial begin
    model_reset();
    // basic capture
    tbl.push_back(mkv(1, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mkv(1, 2, 0, 1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mkv(1, 3, 0, 1, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 1, 0, 1, 0));
    // backpressure: two frames, second waits in the capture bank
    for (int p = 0; p < 4; p++) tbl.push_back(mkv(1, p, 0, 0, 1, 0, 1, p == 3, 1, 0));
    for (int p = 0; p < 3; p++) tbl.push_back(mkv(1, p, 0, 0, 2, 0, 1, 1, 1, 0));
    tbl.push_back(mkv(1, 3, 0, 0, 2, 0, 0, 1, 1, 0));
    tbl.push_back(mkv(1, 0, 0, 0, 9, 0, 0, 1, 1, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 1, 1, 2, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 1, 0, 3, 0));
    // phase error at p=1, then a clean frame keeps the flag
    tbl.push_back(mkv(1, 0, 0, 1, 3, 0, 1, 0, 3, 0));
    tbl.push_back(mkv(1, 2, 0, 1, 3, 0, 1, 0, 3, 1));
    tbl.push_back(mkv(1, 2, 0, 1, 3, 0, 1, 0, 3, 1));
    tbl.push_back(mkv(1, 3, 0, 1, 3, 2, 1, 1, 3, 1));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 1, 0, 4, 1));
    for (int p = 0; p < 4; p++) tbl.push_back(mkv(1, p, 0, 1, 4, 0, 1, p == 3, 4, 1));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 1, 0, 5, 1));
    // flush after two beats, beat on the flush cycle is ignored
    tbl.push_back(mkv(1, 0, 0, 1, 5, 0, 1, 0, 5, 1));
    tbl.push_back(mkv(1, 1, 0, 1, 5, 0, 1, 0, 5, 1));
    tbl.push_back(mkv(1, 2, 1, 1, 5, 0, 1, 0, 5, 1));
    for (int p = 0; p < 4; p++) tbl.push_back(mkv(1, p, 0, 1, 6, 0, 1, p == 3, 5, 1));
    tbl.push_back(mkv(0, 0, 0, 1, 0, 0, 1, 0, 6, 1));

    @(negedge clk);
    do_reset("init");

    for (int i = 0; i < tbl.size(); i++) begin
      string nm;
      nm = $sformatf("row%0d", i);
      in_valid = tbl[i].v;
      in_phase = 2'(tbl[i].ph);
      flush = tbl[i].fl;
      out_ready = tbl[i].ord;
      in_data = tbeat(tbl[i].tag, tbl[i].ph);
      tick(nm);
      chk({nm, " t_rdy"}, 64'(in_ready), 64'(tbl[i].e_rdy));
      chk({nm, " t_ov"}, 64'(out_valid), 64'(tbl[i].e_ov));
      chk({nm, " t_cnt"}, 64'(frame_cnt), 64'(tbl[i].e_cnt));
      chk({nm, " t_err"}, 64'(phase_err), 64'(tbl[i].e_err));
      if (tbl[i].chk == 1)
        for (int m = 0; m < NM; m++)
          for (int j = 0; j < 2; j++)
            for (int p = 0; p < NP; p++)
              chk($sformatf("%s word%0d", nm, m*8 + j*4 + p),
                  out_frame[W*(m*8 + j*4 + p) +: W], tword(0, m, j, p));
      if (tbl[i].chk == 2)
        for (int m = 0; m < NM; m++)
          for (int j = 0; j < 2; j++)
            chk($sformatf("%s perr word%0d", nm, m*8 + j*4 + 1),
                out_frame[W*(m*8 + j*4 + 1) +: W], tword(3, m, j, 2));
    end
    flush = 1'b0;

    // reset mid-frame while a frame is presented
    for (int p = 0; p < 4; p++) beat(1, p, 7, 0, "pre_rst_a");
    beat(1, 0, 8, 0, "pre_rst_b");
    beat(1, 1, 8, 0, "pre_rst_c");
    chk("pre_rst ov", 64'(out_valid), 64'd1);
    do_reset("midrst");
    for (int p = 0; p < 4; p++) beat(1, p, 10, 1, "post_rst");
    beat(0, 0, 0, 1, "post_rst_drain");
    chk("post_rst cnt", 64'(frame_cnt), 64'd1);
    chk("post_rst err", 64'(phase_err), 64'd0);

    // frame counter wrap over 256 deliveries
    do_reset("wraprst");
    for (int f = 0; f < 256; f++)
      for (int p = 0; p < 4; p++) beat(1, p, f, 1, "wrap");
    chk("wrap pre cnt", 64'(frame_cnt), 64'd255);
    beat(0, 0, 0, 1, "wrap_drain");
    chk("wrap cnt", 64'(frame_cnt), 64'd0);

    // randomized traffic
    do_reset("rndrst");
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = $urandom_range(0, 1) != 0;
      flush = ($urandom_range(0, 39) == 0);
      in_phase = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : 2'(mp);
      for (int k = 0; k < 2*NM; k++) in_data[W*k +: W] = {$urandom, $urandom};
      tick("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
